// File: rtl/gtx_rx_packet_decoder_if.sv
// Signal bundle between one GTX lane receiver and the packet decoder.
// master = the lane/word source side, slave = the decoder.
interface gtx_rx_packet_decoder_if;
  logic [31:0] RxData;
  logic        RxCharIsK;
  // LinkDataValid qualifies LinkData/LinkDataAddress/SOP/EOP for exactly one cycle;
  // there is no ready: the consumer must accept every valid beat.
  logic [11:0] LinkPacketAddress;
  logic [11:0] LinkPacketLength;
  logic [15:0] LinkDataAddress;
  logic [31:0] LinkData;
  logic        LinkDataValid;
  logic        LinkStartOfPacket;
  logic        LinkEndOfPacket;
  logic        PacketDone;
  logic        PacketError;
  logic [15:0] PacketCount;
  logic [15:0] ErrorCount;
  logic [1:0]  DebugState;

  modport master (
    output RxData, RxCharIsK,
    input  LinkPacketAddress, LinkPacketLength, LinkDataAddress, LinkData,
           LinkDataValid, LinkStartOfPacket, LinkEndOfPacket,
           PacketDone, PacketError, PacketCount, ErrorCount, DebugState
  );

  modport slave (
    input  RxData, RxCharIsK,
    output LinkPacketAddress, LinkPacketLength, LinkDataAddress, LinkData,
           LinkDataValid, LinkStartOfPacket, LinkEndOfPacket,
           PacketDone, PacketError, PacketCount, ErrorCount, DebugState
  );
endinterface

// File: rtl/gtx_rx_packet_decoder.sv
// Parses the GTX lane word stream into framed packets (header K-word, payload, optional checksum).
// Define RX_CHECKSUM_EN to add the trailing checksum word check (CSUM state + accumulator).
module gtx_rx_packet_decoder #(
  parameter int unsigned MAX_LEN    = 1024,
  parameter logic [7:0]  SOP_CHAR   = 8'h5C,
  parameter logic [7:0]  COMMA_CHAR = 8'h3C
) (
  input logic clk,
  input logic Reset,
  gtx_rx_packet_decoder_if.slave Link
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef RX_CHECKSUM_EN
    StData = 2'd1,
    StCsum = 2'd2
`else
    StData = 2'd1
`endif
  } state_t;

  state_t      state, stateNext;
  logic [11:0] pktAddrQ, pktAddrNext;
  logic [11:0] pktLenQ, pktLenNext;
  logic [11:0] indexQ, indexNext;
  logic [31:0] dataQ, dataNext;
  logic [15:0] dataAddrQ, dataAddrNext;
  logic        validQ, validNext;
  logic        sopQ, sopNext;
  logic        eopQ, eopNext;
  logic        doneQ, doneNext;
  logic        errQ, errNext;
  logic [15:0] pktCntQ, errCntQ;
`ifdef RX_CHECKSUM_EN
  logic [31:0] sumQ, sumNext;
`endif

  logic        isHeader, isComma, isOtherK, hdrOk, lastWord, takeHeader;
  logic [11:0] hdrLen, hdrAddr;

  assign isHeader = Link.RxCharIsK && (Link.RxData[7:0] == SOP_CHAR);
  assign isComma  = Link.RxCharIsK && (Link.RxData[7:0] == COMMA_CHAR);
  assign isOtherK = Link.RxCharIsK && !isHeader && !isComma;
  assign hdrLen   = Link.RxData[31:20];
  assign hdrAddr  = Link.RxData[19:8];
  assign hdrOk    = (hdrLen != 12'd0) && (32'(hdrLen) <= MAX_LEN);
  assign lastWord = (indexQ == (pktLenQ - 12'd1));

  always_comb begin
    stateNext    = state;
    pktAddrNext  = pktAddrQ;
    pktLenNext   = pktLenQ;
    indexNext    = indexQ;
    dataNext     = dataQ;
    dataAddrNext = dataAddrQ;
    validNext    = 1'b0;
    sopNext      = 1'b0;
    eopNext      = 1'b0;
    doneNext     = 1'b0;
    errNext      = 1'b0;
    takeHeader   = 1'b0;
`ifdef RX_CHECKSUM_EN
    sumNext      = sumQ;
`endif

    // Commas fall through every branch untouched, so they simply stall the packet.
    case (state)
      StIdle: begin
        if (isHeader) takeHeader = 1'b1;
      end
      StData: begin
        if (isHeader) begin
          errNext    = 1'b1;
          takeHeader = 1'b1;
        end else if (isOtherK) begin
          errNext   = 1'b1;
          stateNext = StIdle;
        end else if (!Link.RxCharIsK) begin
          validNext    = 1'b1;
          dataNext     = Link.RxData;
          dataAddrNext = {4'b0, pktAddrQ} + {4'b0, indexQ};
          sopNext      = (indexQ == 12'd0);
          eopNext      = lastWord;
          indexNext    = indexQ + 12'd1;
`ifdef RX_CHECKSUM_EN
          sumNext = sumQ + Link.RxData;
          if (lastWord) stateNext = StCsum;
`else
          if (lastWord) begin
            doneNext  = 1'b1;
            stateNext = StIdle;
          end
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      StCsum: begin
        if (isHeader) begin
          errNext    = 1'b1;
          takeHeader = 1'b1;
        end else if (isOtherK) begin
          errNext   = 1'b1;
          stateNext = StIdle;
        end else if (!Link.RxCharIsK) begin
          doneNext  = (Link.RxData == sumQ);
          errNext   = (Link.RxData != sumQ);
          stateNext = StIdle;
        end
      end
`endif
      default: stateNext = StIdle;
    endcase

    // An abort-and-restart header raises errNext once above; a bad header here only re-asserts it.
    if (takeHeader) begin
      if (hdrOk) begin
        pktAddrNext = hdrAddr;
        pktLenNext  = hdrLen;
        indexNext   = 12'd0;
        stateNext   = StData;
`ifdef RX_CHECKSUM_EN
        sumNext = 32'd0;
`endif
      end else begin
        errNext   = 1'b1;
        stateNext = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      pktAddrQ  <= 12'd0;
      pktLenQ   <= 12'd0;
      indexQ    <= 12'd0;
      dataQ     <= 32'd0;
      dataAddrQ <= 16'd0;
      validQ    <= 1'b0;
      sopQ      <= 1'b0;
      eopQ      <= 1'b0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      pktCntQ   <= 16'd0;
      errCntQ   <= 16'd0;
`ifdef RX_CHECKSUM_EN
      sumQ      <= 32'd0;
`endif
    end else begin
      state     <= stateNext;
      pktAddrQ  <= pktAddrNext;
      pktLenQ   <= pktLenNext;
      indexQ    <= indexNext;
      dataQ     <= dataNext;
      dataAddrQ <= dataAddrNext;
      validQ    <= validNext;
      sopQ      <= sopNext;
      eopQ      <= eopNext;
      doneQ     <= doneNext;
      errQ      <= errNext;
      if (doneNext && (pktCntQ != 16'hFFFF)) pktCntQ <= pktCntQ + 16'd1;
      if (errNext && (errCntQ != 16'hFFFF)) errCntQ <= errCntQ + 16'd1;
`ifdef RX_CHECKSUM_EN
      sumQ      <= sumNext;
`endif
    end
  end

  assign Link.LinkPacketAddress = pktAddrQ;
  assign Link.LinkPacketLength  = pktLenQ;
  assign Link.LinkDataAddress   = dataAddrQ;
  assign Link.LinkData          = dataQ;
  assign Link.LinkDataValid     = validQ;
  assign Link.LinkStartOfPacket = sopQ;
  assign Link.LinkEndOfPacket   = eopQ;
  assign Link.PacketDone        = doneQ;
  assign Link.PacketError       = errQ;
  assign Link.PacketCount       = pktCntQ;
  assign Link.ErrorCount        = errCntQ;
  assign Link.DebugState        = state;

endmodule
